// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between fetch (f) and data (d) ports.
// Rejects illegal requests without bus activity and aborts bus accesses that exceed a timeout.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req_rdwr,
  input  logic                  f_req_write,
  input  logic [1:0]            f_req_data_size,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] f_data_out,
  output logic                  f_done,
  output logic                  f_err,
  output logic [DATA_WIDTH-1:0] f_data_in,
  input  logic                  d_req_rdwr,
  input  logic                  d_req_write,
  input  logic [1:0]            d_req_data_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_data_out,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_data_in,
  output logic                  mem_req_rdwr,
  output logic                  mem_req_write,
  output logic [1:0]            mem_req_data_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [1:0]            state, state_nxt;
  logic                  last_d, last_d_nxt;
  logic                  owner_d, owner_d_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  f_done_nxt, f_err_nxt, d_done_nxt, d_err_nxt;
  logic [DATA_WIDTH-1:0] f_data_in_nxt, d_data_in_nxt;
  logic                  mem_req_rdwr_nxt, mem_req_write_nxt;
  logic [1:0]            mem_req_data_size_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_data_out_nxt;

  logic                  any_req_c;
  logic                  win_d_c;
  logic                  win_write_c;
  logic [1:0]            win_size_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [DATA_WIDTH-1:0] win_wdata_c;
  logic                  win_illegal_c;

  // Pick the winner (ties go to the port not granted last) and check its legality
  always_comb begin
    any_req_c = f_req_rdwr | d_req_rdwr;
    if (f_req_rdwr && d_req_rdwr) win_d_c = ~last_d;
    else                          win_d_c = d_req_rdwr;
    win_write_c   = win_d_c ? d_req_write     : f_req_write;
    win_size_c    = win_d_c ? d_req_data_size : f_req_data_size;
    win_addr_c    = win_d_c ? d_addr          : f_addr;
    win_wdata_c   = win_d_c ? d_data_out      : f_data_out;
    win_illegal_c = (win_size_c == 2'd3)
                  | ((win_size_c == 2'd1) & win_addr_c[0])
                  | ((win_size_c == 2'd2) & (win_addr_c[1:0] != 2'b00))
                  | (~win_d_c & win_write_c);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt             = state;
    last_d_nxt            = last_d;
    owner_d_nxt           = owner_d;
    cnt_nxt               = cnt;
    f_done_nxt            = 1'b0;
    f_err_nxt             = 1'b0;
    d_done_nxt            = 1'b0;
    d_err_nxt             = 1'b0;
    f_data_in_nxt         = f_data_in;
    d_data_in_nxt         = d_data_in;
    mem_req_rdwr_nxt      = mem_req_rdwr;
    mem_req_write_nxt     = mem_req_write;
    mem_req_data_size_nxt = mem_req_data_size;
    mem_addr_nxt          = mem_addr;
    mem_data_out_nxt      = mem_data_out;
    case (state)
      S_IDLE: begin
        if (any_req_c) begin
          last_d_nxt  = win_d_c;
          owner_d_nxt = win_d_c;
          if (win_illegal_c) begin
            state_nxt = S_DONE;
            if (win_d_c) begin
              d_done_nxt    = 1'b1;
              d_err_nxt     = 1'b1;
              d_data_in_nxt = '0;
            end else begin
              f_done_nxt    = 1'b1;
              f_err_nxt     = 1'b1;
              f_data_in_nxt = '0;
            end
          end else begin
            state_nxt             = S_BUSY;
            cnt_nxt               = '0;
            mem_req_rdwr_nxt      = 1'b1;
            mem_req_write_nxt     = win_write_c;
            mem_req_data_size_nxt = win_size_c;
            mem_addr_nxt          = win_addr_c;
            mem_data_out_nxt      = win_wdata_c;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_nxt         = S_DONE;
          mem_req_rdwr_nxt  = 1'b0;
          mem_req_write_nxt = 1'b0;
          if (owner_d) begin
            d_done_nxt = 1'b1;
            if (!mem_req_write) d_data_in_nxt = mem_data_in;
          end else begin
            f_done_nxt = 1'b1;
            if (!mem_req_write) f_data_in_nxt = mem_data_in;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt         = S_DONE;
          mem_req_rdwr_nxt  = 1'b0;
          mem_req_write_nxt = 1'b0;
          if (owner_d) begin
            d_done_nxt    = 1'b1;
            d_err_nxt     = 1'b1;
            d_data_in_nxt = '0;
          end else begin
            f_done_nxt    = 1'b1;
            f_err_nxt     = 1'b1;
            f_data_in_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      last_d            <= 1'b0;
      owner_d           <= 1'b0;
      cnt               <= '0;
      f_done            <= 1'b0;
      f_err             <= 1'b0;
      f_data_in         <= '0;
      d_done            <= 1'b0;
      d_err             <= 1'b0;
      d_data_in         <= '0;
      mem_req_rdwr      <= 1'b0;
      mem_req_write     <= 1'b0;
      mem_req_data_size <= '0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
    end else begin
      state             <= state_nxt;
      last_d            <= last_d_nxt;
      owner_d           <= owner_d_nxt;
      cnt               <= cnt_nxt;
      f_done            <= f_done_nxt;
      f_err             <= f_err_nxt;
      f_data_in         <= f_data_in_nxt;
      d_done            <= d_done_nxt;
      d_err             <= d_err_nxt;
      d_data_in         <= d_data_in_nxt;
      mem_req_rdwr      <= mem_req_rdwr_nxt;
      mem_req_write     <= mem_req_write_nxt;
      mem_req_data_size <= mem_req_data_size_nxt;
      mem_addr          <= mem_addr_nxt;
      mem_data_out      <= mem_data_out_nxt;
    end
  end

endmodule
